// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: issues one 4-beat line read per cache miss, steers beats into the return buffer, flags burst protocol errors
module icache_refill_ctrl #(
  parameter int ADDR_W = 32,
  parameter int BEATS  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              miss_req,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic              miss_ready,
  input  logic              cancel,
  output logic              o_arvalid,
  output logic [ADDR_W-1:0] o_araddr,
  output logic [7:0]        o_arlen,
  input  logic              i_arready,
  input  logic              i_rvalid,
  input  logic              i_rlast,
  output logic              o_rready,
  output logic              buf_shift,
  output logic [1:0]        buf_offset,
  output logic              refill_we,
  output logic              refill_done,
  output logic              refill_err
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, WRITE, DRAIN} state_t;
  state_t     state;
  logic [1:0] cnt;
  logic       bad;
  logic       beat;
  logic       beat_err;
  assign miss_ready  = state == IDLE;
  assign o_arvalid   = state == ADDR;
  assign o_rready    = state == DATA || state == DRAIN;
  assign refill_we   = state == WRITE;
  assign refill_done = state == WRITE;
  assign o_arlen     = 8'(BEATS - 1);
  assign beat        = i_rvalid & o_rready;
  assign buf_shift   = beat & (state == DATA) & ~cancel;
  assign beat_err    = beat & (i_rlast ^ (cnt == 2'(BEATS - 1)));
  // Refill sequencing; bad remembers a malformed burst so its WRITE is suppressed
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      bad        <= 1'b0;
      o_araddr   <= '0;
      buf_offset <= 2'd0;
      refill_err <= 1'b0;
    end else begin
      if (beat_err) refill_err <= 1'b1;
      if (beat) cnt <= cnt + 2'd1;
      case (state)
        IDLE: if (miss_req && !cancel) begin
          state      <= ADDR;
          o_araddr   <= {miss_addr[ADDR_W-1:4], 4'b0};
          buf_offset <= miss_addr[3:2];
          bad        <= 1'b0;
        end
        ADDR: if (i_arready) begin
          state <= cancel ? DRAIN : DATA;
          cnt   <= 2'd0;
        end else if (cancel) state <= IDLE;
        DATA: begin
          if (beat_err) bad <= 1'b1;
          if (beat && i_rlast) state <= (cancel || bad || beat_err) ? IDLE : WRITE;
          else if (cancel) state <= DRAIN;
        end
        WRITE: state <= IDLE;
        DRAIN: if (beat && i_rlast) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: directed scenarios with a scoreboard of expected AR addresses and refill offsets
module tb_icache_refill_ctrl;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        miss_req = 1'b0;
  logic [31:0] miss_addr = '0;
  logic        miss_ready;
  logic        cancel = 1'b0;
  logic        o_arvalid;
  logic [31:0] o_araddr;
  logic [7:0]  o_arlen;
  logic        i_arready = 1'b0;
  logic        i_rvalid = 1'b0;
  logic        i_rlast = 1'b0;
  logic        o_rready;
  logic        buf_shift;
  logic [1:0]  buf_offset;
  logic        refill_we;
  logic        refill_done;
  logic        refill_err;
  int          tests = 0;
  int          fails = 0;
  int          n_shift = 0;
  int          s0;
  logic [31:0] exp_ar[$];
  logic [1:0]  exp_off[$];

  icache_refill_ctrl #(.ADDR_W(32), .BEATS(4)) dut (
    .clk(clk), .rstn(rstn), .miss_req(miss_req), .miss_addr(miss_addr),
    .miss_ready(miss_ready), .cancel(cancel), .o_arvalid(o_arvalid),
    .o_araddr(o_araddr), .o_arlen(o_arlen), .i_arready(i_arready),
    .i_rvalid(i_rvalid), .i_rlast(i_rlast), .o_rready(o_rready),
    .buf_shift(buf_shift), .buf_offset(buf_offset), .refill_we(refill_we),
    .refill_done(refill_done), .refill_err(refill_err)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  // Mid-cycle monitor: pops the scoreboard on AR handshakes and refill writes, counts shifts
  always @(negedge clk) begin
    if (buf_shift) n_shift++;
    if (o_arvalid && i_arready) begin
      chk("ar_expected", 32'(exp_ar.size() != 0), 1);
      if (exp_ar.size() != 0) chk("araddr", o_araddr, exp_ar.pop_front());
      chk("arlen", 32'(o_arlen), 3);
    end
    if (refill_we || refill_done) begin
      chk("we_eq_done", 32'(refill_we), 32'(refill_done));
      chk("refill_expected", 32'(exp_off.size() != 0), 1);
      if (exp_off.size() != 0) chk("buf_offset", 32'(buf_offset), 32'(exp_off.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic miss(input logic [31:0] a);
    miss_req = 1'b1;
    miss_addr = a;
    tick();
    miss_req = 1'b0;
  endtask

  task automatic grant(input logic [31:0] a, input int late);
    repeat (late) begin
      chk("arvalid_hold", 32'(o_arvalid), 1);
      chk("araddr_hold", o_araddr, {a[31:4], 4'b0});
      tick();
    end
    i_arready = 1'b1;
    exp_ar.push_back({a[31:4], 4'b0});
    tick();
    i_arready = 1'b0;
  endtask

  task automatic beat(input logic last, input int gap);
    i_rvalid = 1'b1;
    i_rlast = last;
    tick();
    i_rvalid = 1'b0;
    i_rlast = 1'b0;
    repeat (gap) tick();
  endtask

  initial begin
    tick();
    tick();
    chk("rst_miss_ready", 32'(miss_ready), 1);
    chk("rst_arvalid", 32'(o_arvalid), 0);
    chk("rst_rready", 32'(o_rready), 0);
    chk("rst_araddr", o_araddr, 0);
    chk("rst_offset", 32'(buf_offset), 0);
    chk("rst_err", 32'(refill_err), 0);
    chk("rst_we", 32'(refill_we), 0);
    rstn = 1'b1;
    tick();
    s0 = n_shift;
    i_rvalid = 1'b1;
    chk("idle_rready", 32'(o_rready), 0);
    tick();
    i_rvalid = 1'b0;
    chk("idle_rvalid_ignored", 32'(miss_ready), 1);
    // Late arready, back-to-back beats
    miss(32'h1C00_0038);
    chk("t1_arvalid", 32'(o_arvalid), 1);
    chk("t1_araddr", o_araddr, 32'h1C00_0030);
    chk("t1_offset", 32'(buf_offset), 2);
    chk("t1_miss_ready", 32'(miss_ready), 0);
    exp_off.push_back(2'd2);
    grant(32'h1C00_0038, 2);
    chk("t1_rready", 32'(o_rready), 1);
    for (int i = 0; i < 4; i++) beat(i == 3, 0);
    chk("t1_we", 32'(refill_we), 1);
    chk("t1_done", 32'(refill_done), 1);
    chk("t1_ready_n1", 32'(miss_ready), 0);
    tick();
    chk("t1_we_off", 32'(refill_we), 0);
    chk("t1_ready_n2", 32'(miss_ready), 1);
    chk("t1_shifts", 32'(n_shift - s0), 4);
    chk("t1_drained", 32'(exp_off.size()), 0);
    // Gapped beats
    s0 = n_shift;
    miss(32'h0000_1004);
    exp_off.push_back(2'd1);
    grant(32'h0000_1004, 0);
    for (int i = 0; i < 4; i++) beat(i == 3, i == 3 ? 0 : 1);
    cancel = 1'b1;
    chk("t2_we", 32'(refill_we), 1);
    tick();
    cancel = 1'b0;
    chk("t2_idle", 32'(miss_ready), 1);
    chk("t2_shifts", 32'(n_shift - s0), 4);
    chk("t2_err", 32'(refill_err), 0);
    chk("t2_drained", 32'(exp_off.size()), 0);
    // Cancel in ADDR before arready
    miss(32'h2000_0040);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("t3_arvalid", 32'(o_arvalid), 0);
    chk("t3_idle", 32'(miss_ready), 1);
    // Cancel after two beats, drain the rest
    s0 = n_shift;
    miss(32'h3000_0008);
    grant(32'h3000_0008, 1);
    beat(1'b0, 0);
    beat(1'b0, 0);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("t3_drain_rready", 32'(o_rready), 1);
    chk("t3_drain_busy", 32'(miss_ready), 0);
    beat(1'b0, 0);
    beat(1'b1, 0);
    chk("t3_idle2", 32'(miss_ready), 1);
    chk("t3_shifts", 32'(n_shift - s0), 2);
    chk("t3_err", 32'(refill_err), 0);
    // Early rlast
    miss(32'h4000_0000);
    grant(32'h4000_0000, 0);
    beat(1'b0, 0);
    beat(1'b1, 0);
    chk("t4_idle", 32'(miss_ready), 1);
    chk("t4_no_we", 32'(refill_we), 0);
    chk("t4_err", 32'(refill_err), 1);
    miss(32'h5000_000C);
    exp_off.push_back(2'd3);
    grant(32'h5000_000C, 0);
    for (int i = 0; i < 4; i++) beat(i == 3, 0);
    chk("t4_we", 32'(refill_we), 1);
    tick();
    chk("t4_err_sticky", 32'(refill_err), 1);
    chk("t4_drained", 32'(exp_off.size()), 0);
    // Request held high through a refill
    miss_req = 1'b1;
    miss_addr = 32'h6000_0004;
    tick();
    miss_addr = 32'h7000_0008;
    exp_off.push_back(2'd1);
    grant(32'h6000_0004, 0);
    for (int i = 0; i < 4; i++) beat(i == 3, 0);
    chk("t5_write_busy", 32'(miss_ready), 0);
    chk("t5_write_noar", 32'(o_arvalid), 0);
    tick();
    chk("t5_ready_back", 32'(miss_ready), 1);
    tick();
    chk("t5_second_ar", 32'(o_arvalid), 1);
    chk("t5_second_addr", o_araddr, 32'h7000_0000);
    chk("t5_second_off", 32'(buf_offset), 2);
    miss_req = 1'b0;
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("t5_cancel_idle", 32'(miss_ready), 1);
    chk("t5_drained", 32'(exp_off.size()), 0);
    // Async reset during beat 1
    miss(32'h8000_0010);
    grant(32'h8000_0010, 0);
    beat(1'b0, 0);
    i_rvalid = 1'b1;
    #2 rstn = 1'b0;
    #1;
    chk("t6_miss_ready", 32'(miss_ready), 1);
    chk("t6_rready", 32'(o_rready), 0);
    chk("t6_shift", 32'(buf_shift), 0);
    chk("t6_araddr", o_araddr, 0);
    chk("t6_offset", 32'(buf_offset), 0);
    chk("t6_err", 32'(refill_err), 0);
    i_rvalid = 1'b0;
    tick();
    rstn = 1'b1;
    i_rvalid = 1'b1;
    i_rlast = 1'b1;
    tick();
    i_rvalid = 1'b0;
    i_rlast = 1'b0;
    tick();
    chk("t6_after_ready", 32'(miss_ready), 1);
    chk("t6_no_we", 32'(refill_we), 0);
    chk("t6_drained", 32'(exp_off.size()), 0);
    // Missing rlast on beat 4
    s0 = n_shift;
    miss(32'h9000_0020);
    grant(32'h9000_0020, 0);
    for (int i = 0; i < 4; i++) beat(1'b0, 0);
    chk("t7_err", 32'(refill_err), 1);
    chk("t7_still_data", 32'(o_rready), 1);
    beat(1'b1, 0);
    chk("t7_idle", 32'(miss_ready), 1);
    chk("t7_no_we", 32'(refill_we), 0);
    chk("t7_shifts", 32'(n_shift - s0), 5);
    tick();
    chk("t7_ar_drained", 32'(exp_ar.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/icache_refill_ctrl.md
ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 Parameter: ADDR_W, 32, address width.
REQ-002 Parameter: BEATS, 4, 32-bit beats per line (fixed; 128-bit line).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rstn  in  1  asynchronous, active-low reset.
REQ-005 miss_req  in  1  miss request from cache lookup stage.
REQ-006 miss_addr  in  ADDR_W  missing word address; valid with miss_req.
REQ-007 miss_ready  out  1  high only in IDLE; request accepted when miss_req & miss_ready.
REQ-008 cancel  in  1  pipeline flush; aborts current refill.
REQ-009 o_arvalid  out  1  read-address valid.
REQ-010 o_araddr  out  ADDR_W  line-aligned address: {miss_addr[ADDR_W-1:4], 4'b0}.
REQ-011 o_arlen  out  8  constant BEATS-1 (8'd3).
REQ-012 i_arready  in  1  read-address ready.
REQ-013 i_rvalid, i_rlast  in  1 each  read-data valid / last beat.
REQ-014 o_rready  out  1  read-data ready.
REQ-015 buf_shift  out  1  return-buffer shift enable; one pulse per accepted beat.
REQ-016 buf_offset  out  2  latched miss_addr[3:2], selects requested word from return buffer.
REQ-017 refill_we  out  1  one-cycle cache line write enable.
REQ-018 refill_done  out  1  one-cycle pulse: requested word valid on return-buffer output.
REQ-019 refill_err  out  1  sticky protocol-error flag, cleared only by reset.

Function
REQ-020 States: IDLE, ADDR, DATA, WRITE, DRAIN; encoding free.
REQ-021 IDLE: miss_req & ~cancel -> latch araddr/offset, go ADDR next cycle; cancel with miss_req ignores request.
REQ-022 ADDR: o_arvalid=1, araddr/arlen stable until i_arready; on handshake -> DATA, beat counter=0.
REQ-023 ADDR with cancel and no handshake same cycle -> IDLE, o_arvalid deasserts next cycle; cancel with handshake -> DRAIN.
REQ-024 DATA/DRAIN: o_rready=1; beat accepted when i_rvalid & o_rready; 2-bit counter increments per beat, wraps 3->0.
REQ-025 buf_shift = beat accepted in DATA (combinational, same cycle); buf_shift=0 in DRAIN.
REQ-026 DATA: beat with i_rlast -> WRITE; cancel in DATA -> DRAIN (if that cycle is also rlast beat -> IDLE, no shift).
REQ-027 WRITE: refill_we=1 and refill_done=1 for exactly one cycle, then IDLE; cancel in WRITE ignored.
REQ-028 DRAIN: consume beats without buffering until beat with i_rlast -> IDLE; no refill_we/refill_done.
REQ-029 Latency: last beat at cycle N -> refill_we/refill_done at N+1; miss_ready at N+2.
REQ-030 Error: i_rlast on counter!=3, or beat with counter==3 and ~i_rlast -> refill_err=1; rlast still terminates burst; on early rlast go IDLE, no WRITE; missing rlast: stay until rlast, suppress WRITE.
REQ-031 i_rvalid in IDLE/ADDR/WRITE ignored; o_rready=0 there.
REQ-032 o_arvalid, o_rready, buf_shift, refill_we, refill_done registered or decoded from state only; no combinational path from i_arready to o_arvalid.

Reset
REQ-033 rstn low: state=IDLE, counter=0, o_araddr=0, buf_offset=0, refill_err=0, all valid/enable outputs 0, miss_ready=1.
REQ-034 Reset mid-burst abandons transaction; no refill_we after release.

Verification
REQ-035 miss_addr=0x1C00_0038, arready 2 cycles late, 4 beats back-to-back -> araddr=0x1C00_0030, arlen=3, 4 buf_shift pulses, buf_offset=2, refill_we+refill_done 1 cycle after rlast.
REQ-036 Beats with 1-cycle rvalid gaps -> buf_shift only on valid cycles, counter 0..3, single WRITE.
REQ-037 cancel in ADDR before arready -> IDLE, no ar handshake; cancel after 2 beats -> DRAIN, remaining 2 beats consumed, buf_shift=0, no refill_we.
REQ-038 rlast on beat 2 -> refill_err=1, IDLE, no refill_we; next miss still serviced, err stays 1.
REQ-039 rstn low during DATA beat 1 -> all outputs reset values asynchronously, miss_ready=1 after release.
REQ-040 miss_req held high through refill -> second request accepted only on cycle miss_ready returns.
